// File: rtl/uart_prog_loader.sv
// UART 8N1 program loader: deserialises bytes, packs them little-endian into 32-bit words
// and writes each word to instruction memory until the terminator word arrives.
module uart_prog_loader #(
  parameter int unsigned CLKS_PER_BIT = 347,
  parameter int unsigned ADDR_WIDTH   = 14,
  parameter logic [31:0] END_WORD     = 32'h0000_0FFF
) (
  input  logic                  clk,
  input  logic                  rst_l,
  input  logic                  en_i,
  input  logic                  rx_i,
  output logic                  mem_we_o,
  output logic [ADDR_WIDTH-1:0] mem_addr_o,
  output logic [31:0]           mem_wdata_o,
  output logic                  busy_o,
  output logic                  done_o,
  output logic                  frame_err_o,
  output logic                  wrap_o
);

  localparam int unsigned CntW = $clog2(CLKS_PER_BIT);
  localparam logic [CntW-1:0] HalfEnd = CntW'(CLKS_PER_BIT / 2 - 1);
  localparam logic [CntW-1:0] BitEnd  = CntW'(CLKS_PER_BIT - 1);

  typedef enum logic [2:0] {StIdle, StStart, StData, StStop, StWaitHi} state_e;

  state_e                state_q, state_d;
  logic                  rx_meta_q, rx_s_q;
  logic [CntW-1:0]       cnt_q, cnt_d;
  logic [2:0]            bit_q, bit_d;
  logic [7:0]            shreg_q, shreg_d;
  logic                  busy_q, busy_d;
  logic                  byte_vld, ferr_set;
  logic [23:0]           word_q, word_d;
  logic [1:0]            bidx_q, bidx_d;
  logic [ADDR_WIDTH-1:0] waddr_q, waddr_d;
  logic [ADDR_WIDTH-1:0] mem_addr_q, mem_addr_d;
  logic [31:0]           mem_wdata_q, mem_wdata_d;
  logic [31:0]           full_word;
  logic                  mem_we_q, mem_we_d;
  logic                  done_q, done_d;
  logic                  ferr_q, ferr_d;
  logic                  wrap_q, wrap_d;

  // Receiver: counts from the start edge to mid-bit, then one full bit period per sample.
  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q + 1'b1;
    bit_d    = bit_q;
    shreg_d  = shreg_q;
    byte_vld = 1'b0;
    ferr_set = 1'b0;
    unique case (state_q)
      StIdle: begin
        cnt_d = '0;
        if (!done_q && !rx_s_q) state_d = StStart;
      end
      StStart: begin
        if (cnt_q == HalfEnd) begin
          cnt_d   = '0;
          bit_d   = '0;
          state_d = rx_s_q ? StIdle : StData;
        end
      end
      StData: begin
        if (cnt_q == BitEnd) begin
          cnt_d   = '0;
          shreg_d = {rx_s_q, shreg_q[7:1]};
          bit_d   = bit_q + 3'd1;
          if (bit_q == 3'd7) state_d = StStop;
        end
      end
      StStop: begin
        if (cnt_q == BitEnd) begin
          cnt_d = '0;
          if (rx_s_q) begin
            byte_vld = 1'b1;
            state_d  = StIdle;
          end else begin
            ferr_set = 1'b1;
            state_d  = StWaitHi;
          end
        end
      end
      StWaitHi: begin
        cnt_d = '0;
        if (rx_s_q) state_d = StIdle;
      end
      default: state_d = StIdle;
    endcase
    if (!en_i) begin
      state_d  = StIdle;
      cnt_d    = '0;
      byte_vld = 1'b0;
      ferr_set = 1'b0;
    end
    busy_d = (state_q == StStart) || (state_q == StData) || (state_q == StStop);
  end

  // Word assembly and memory write.
  always_comb begin
    word_d      = word_q;
    bidx_d      = bidx_q;
    waddr_d     = waddr_q;
    mem_we_d    = 1'b0;
    mem_addr_d  = mem_addr_q;
    mem_wdata_d = mem_wdata_q;
    done_d      = done_q;
    wrap_d      = wrap_q;
    ferr_d      = ferr_q | ferr_set;
    full_word   = {shreg_q, word_q};
    if (!en_i) begin
      word_d = '0;
      bidx_d = '0;
    end else if (byte_vld) begin
      bidx_d = bidx_q + 2'd1;
      unique case (bidx_q)
        2'd0: word_d[7:0]   = shreg_q;
        2'd1: word_d[15:8]  = shreg_q;
        2'd2: word_d[23:16] = shreg_q;
        2'd3: begin
          word_d = '0;
          if (full_word == END_WORD) begin
            done_d = 1'b1;
          end else begin
            mem_we_d    = 1'b1;
            mem_addr_d  = waddr_q;
            mem_wdata_d = full_word;
            waddr_d     = waddr_q + 1'b1;
            if (waddr_q == '1) wrap_d = 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_l) begin
    if (!rst_l) begin
      rx_meta_q   <= 1'b1;
      rx_s_q      <= 1'b1;
      state_q     <= StIdle;
      cnt_q       <= '0;
      bit_q       <= '0;
      shreg_q     <= '0;
      busy_q      <= 1'b0;
      word_q      <= '0;
      bidx_q      <= '0;
      waddr_q     <= '0;
      mem_we_q    <= 1'b0;
      mem_addr_q  <= '0;
      mem_wdata_q <= '0;
      done_q      <= 1'b0;
      ferr_q      <= 1'b0;
      wrap_q      <= 1'b0;
    end else begin
      rx_meta_q   <= rx_i;
      rx_s_q      <= rx_meta_q;
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      bit_q       <= bit_d;
      shreg_q     <= shreg_d;
      busy_q      <= busy_d;
      word_q      <= word_d;
      bidx_q      <= bidx_d;
      waddr_q     <= waddr_d;
      mem_we_q    <= mem_we_d;
      mem_addr_q  <= mem_addr_d;
      mem_wdata_q <= mem_wdata_d;
      done_q      <= done_d;
      ferr_q      <= ferr_d;
      wrap_q      <= wrap_d;
    end
  end

  assign mem_we_o    = mem_we_q;
  assign mem_addr_o  = mem_addr_q;
  assign mem_wdata_o = mem_wdata_q;
  assign busy_o      = busy_q;
  assign done_o      = done_q;
  assign frame_err_o = ferr_q;
  assign wrap_o      = wrap_q;

endmodule

// File: tb/tb_uart_prog_loader.sv
// Bench for uart_prog_loader: drives 8N1 frames and scoreboards the memory writes.
module tb_uart_prog_loader;

  localparam int unsigned Cpb = 16;
  localparam int unsigned Aw  = 2;

  logic          clk = 1'b0;
  logic          rst_l = 1'b0;
  logic          en_i = 1'b1;
  logic          rx_i = 1'b1;
  logic          mem_we_o;
  logic [Aw-1:0] mem_addr_o;
  logic [31:0]   mem_wdata_o;
  logic          busy_o, done_o, frame_err_o, wrap_o;

  int n_checks = 0;
  int n_fail   = 0;
  logic [Aw+31:0] exp_q[$];
  logic [Aw+31:0] obs_q[$];
  logic prev_we = 1'b0;
  int   we_long = 0;

  uart_prog_loader #(.CLKS_PER_BIT(Cpb), .ADDR_WIDTH(Aw)) dut (
    .clk        (clk),
    .rst_l      (rst_l),
    .en_i       (en_i),
    .rx_i       (rx_i),
    .mem_we_o   (mem_we_o),
    .mem_addr_o (mem_addr_o),
    .mem_wdata_o(mem_wdata_o),
    .busy_o     (busy_o),
    .done_o     (done_o),
    .frame_err_o(frame_err_o),
    .wrap_o     (wrap_o)
  );

  always #5 clk = ~clk;

  // Monitor: record every write strobe and any strobe longer than one cycle.
  always @(negedge clk) begin
    if (mem_we_o) obs_q.push_back({mem_addr_o, mem_wdata_o});
    if (mem_we_o && prev_we) we_long++;
    prev_we = mem_we_o;
  end

  task automatic cyc(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic do_reset();
    rst_l = 1'b0;
    rx_i  = 1'b1;
    en_i  = 1'b1;
    cyc(3);
    exp_q.delete();
    obs_q.delete();
    rst_l = 1'b1;
    cyc(3);
  endtask

  task automatic send_byte(input logic [7:0] b, input logic stop_ok = 1'b1);
    rx_i = 1'b0;
    cyc(Cpb);
    for (int i = 0; i < 8; i++) begin
      rx_i = b[i];
      cyc(Cpb);
    end
    rx_i = stop_ok;
    cyc(Cpb);
    rx_i = 1'b1;
  endtask

  task automatic send_word(input logic [31:0] w);
    for (int i = 0; i < 4; i++) send_byte(w[8*i +: 8]);
  endtask

  task automatic push_exp(input logic [Aw-1:0] a, input logic [31:0] d);
    exp_q.push_back({a, d});
  endtask

  // Drain the scoreboard: every expected write must have been observed, in order.
  task automatic check_writes(input string name);
    logic [Aw+31:0] e, o;
    cyc(Cpb);
    while (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      n_checks++;
      if (obs_q.size() == 0) begin
        n_fail++;
        $display("FAIL %s missing write: got none, want addr=%0d data=%h", name,
                 e[Aw+31:32], e[31:0]);
      end else begin
        o = obs_q.pop_front();
        n_checks++;
        if (o !== e) begin
          n_fail++;
          $display("FAIL %s write: got addr=%0d data=%h, want addr=%0d data=%h", name,
                   o[Aw+31:32], o[31:0], e[Aw+31:32], e[31:0]);
        end
      end
    end
    n_checks++;
    if (obs_q.size() != 0) begin
      n_fail++;
      $display("FAIL %s extra writes: got %0d, want 0", name, obs_q.size());
      obs_q.delete();
    end
    n_checks++;
    if (we_long != 0) begin
      n_fail++;
      $display("FAIL %s we pulse width: got %0d long pulses, want 0", name, we_long);
      we_long = 0;
    end
  endtask

  task automatic test_reset();
    rst_l = 1'b0;
    cyc(2);
    n_checks++;
    if ({mem_we_o, mem_addr_o, mem_wdata_o, busy_o, done_o, frame_err_o, wrap_o} !== '0) begin
      n_fail++;
      $display("FAIL reset outputs: got we=%b addr=%0d data=%h busy=%b done=%b ferr=%b wrap=%b, want all 0",
               mem_we_o, mem_addr_o, mem_wdata_o, busy_o, done_o, frame_err_o, wrap_o);
    end
    do_reset();
    n_checks++;
    if ({mem_we_o, busy_o, done_o, frame_err_o, wrap_o} !== 5'b0) begin
      n_fail++;
      $display("FAIL post_reset flags: got %b, want 00000",
               {mem_we_o, busy_o, done_o, frame_err_o, wrap_o});
    end
  endtask

  task automatic test_single_word();
    do_reset();
    push_exp(2'd0, 32'h0000_0013);
    send_word(32'h0000_0013);
    check_writes("single_word");
    n_checks++;
    if (done_o !== 1'b0) begin
      n_fail++;
      $display("FAIL single_word done: got %b, want 0", done_o);
    end
  endtask

  task automatic test_program();
    logic [31:0] prog [3];
    prog[0] = 32'h0000_0093;
    prog[1] = 32'h0010_0113;
    prog[2] = 32'h0020_81B3;
    do_reset();
    for (int i = 0; i < 3; i++) begin
      push_exp(Aw'(i), prog[i]);
      send_word(prog[i]);
    end
    send_word(32'h0000_0FFF);
    check_writes("program");
    n_checks++;
    if (done_o !== 1'b1) begin
      n_fail++;
      $display("FAIL program done: got %b, want 1", done_o);
    end
    send_word(32'h1234_5678);
    check_writes("after_done");
    n_checks++;
    if (busy_o !== 1'b0) begin
      n_fail++;
      $display("FAIL after_done busy: got %b, want 0", busy_o);
    end
  endtask

  task automatic test_glitch_frame();
    do_reset();
    rx_i = 1'b0;
    cyc(Cpb / 4);
    rx_i = 1'b1;
    cyc(2);
    n_checks++;
    if (busy_o !== 1'b1) begin
      n_fail++;
      $display("FAIL glitch busy_start: got %b, want 1", busy_o);
    end
    cyc(Cpb);
    n_checks++;
    if (busy_o !== 1'b0) begin
      n_fail++;
      $display("FAIL glitch busy_end: got %b, want 0", busy_o);
    end
    send_byte(8'hA5, 1'b0);
    cyc(4);
    n_checks++;
    if (frame_err_o !== 1'b1) begin
      n_fail++;
      $display("FAIL frame_err flag: got %b, want 1", frame_err_o);
    end
    push_exp(2'd0, 32'hDEAD_BEEF);
    send_word(32'hDEAD_BEEF);
    // glitch in the middle of a word must not shift byte positions
    push_exp(2'd1, 32'h4433_2211);
    send_byte(8'h11);
    rx_i = 1'b0;
    cyc(Cpb / 4);
    rx_i = 1'b1;
    cyc(Cpb);
    send_byte(8'h22);
    send_byte(8'h33);
    send_byte(8'h44);
    check_writes("glitch_frame");
  endtask

  task automatic test_enable_drop();
    do_reset();
    send_byte(8'hAA);
    send_byte(8'hBB);
    en_i = 1'b0;
    cyc(3);
    en_i = 1'b1;
    cyc(2);
    push_exp(2'd0, 32'h0403_0201);
    send_word(32'h0403_0201);
    check_writes("enable_drop");
  endtask

  task automatic test_wrap();
    logic [31:0] w;
    do_reset();
    for (int i = 0; i < 5; i++) begin
      w = 32'hA000_0000 + 32'(i);
      push_exp(Aw'(i), w);
      send_word(w);
      cyc(2);
      if (i == 2 || i == 3) begin
        n_checks++;
        if (wrap_o !== (i == 3)) begin
          n_fail++;
          $display("FAIL wrap after write %0d: got %b, want %b", i + 1, wrap_o, i == 3);
        end
      end
    end
    check_writes("wrap");
  endtask

  task automatic test_reset_mid();
    do_reset();
    push_exp(2'd0, 32'h0BAD_F00D);
    send_word(32'h0BAD_F00D);
    send_byte(8'h00, 1'b0);
    check_writes("pre_reset");
    rx_i = 1'b0;
    cyc(Cpb * 3);
    n_checks++;
    if (busy_o !== 1'b1) begin
      n_fail++;
      $display("FAIL reset_mid busy: got %b, want 1", busy_o);
    end
    rst_l = 1'b0;
    #1;
    n_checks++;
    if ({mem_we_o, mem_addr_o, mem_wdata_o, busy_o, done_o, frame_err_o, wrap_o} !== '0) begin
      n_fail++;
      $display("FAIL reset_mid outputs: got addr=%0d data=%h busy=%b ferr=%b, want all 0",
               mem_addr_o, mem_wdata_o, busy_o, frame_err_o);
    end
    rx_i = 1'b1;
    cyc(2);
    rst_l = 1'b1;
    cyc(Cpb);
    push_exp(2'd0, 32'hCAFE_0001);
    send_word(32'hCAFE_0001);
    check_writes("reset_mid");
  endtask

  initial begin
    test_reset();
    test_single_word();
    test_program();
    test_glitch_frame();
    test_enable_drop();
    test_wrap();
    test_reset_mid();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
